aes_ctrl_shadow_seq: RTL and testbench
======================================

# aes_ctrl_shadow_seq

Two-phase write sequencer for the AES core's shadowed control register (`ctrl_reg_t`, 32 bits). A bus write commits only when the same value is written twice in succession while the core is idle. The block keeps an inverted redundant copy of the committed value and flags update mismatches and storage corruption. It sits between the register-bus write decode and `aes_core`, and is the only source of the core's committed control word.

## Interface
- `DW`, default 32: control word width; must equal `$bits(ctrl_reg_t)`.
- `RESVAL`, default `'0`: committed reset value; `CTRL_RESET` in the AES instantiation.

- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `we_i`  in  1  bus write strobe, one cycle per write
- `wdata_i`  in  DW  bus write data
- `re_i`  in  1  bus read strobe of this register
- `core_idle_i`  in  1  AES core idle; writes are accepted only when high
- `q_o`  out  DW  committed control word
- `qe_o`  out  1  one-cycle pulse, `q_o` updated this cycle
- `phase_o`  out  1  0 = awaiting first write, 1 = awaiting confirming write
- `wr_ignored_o`  out  1  one-cycle pulse, write dropped because core busy
- `err_update_o`  out  1  one-cycle pulse, second write mismatched the first
- `err_storage_o`  out  1  sticky, committed copy and redundant copy disagree

## Operation
- Registers:
  - `staged_q` (DW)
  - `q_o` (DW)
  - `shadow_q` (DW), holding the inverse of the committed value
  - `phase_q`
  - the three pulse flops
  - `err_storage_q`
- State machine with two states.
  - STAGE0: `phase_o`=0.
  - STAGE1: `phase_o`=1.
- Accepted write: `we_i`=1 and `core_idle_i`=1.
- STAGE0 + accepted write: `staged_q` ← `wdata_i`; go to STAGE1.
- STAGE1 + accepted write, `wdata_i` == `staged_q`:
  - `q_o` ← `wdata_i`, `shadow_q` ← ~`wdata_i`.
  - Pulse `qe_o`; go to STAGE0.
- STAGE1 + accepted write, mismatch:
  - `q_o` and `shadow_q` unchanged.
  - Pulse `err_update_o`; go to STAGE0.
- `we_i`=1 with `core_idle_i`=0:
  - No state or data change.
  - Pulse `wr_ignored_o`.
- `re_i`=1 while in STAGE1 without an accepted write: go to STAGE0 and discard the staged value.
  - Clear `staged_q` to 0.
- `re_i` and `we_i` in the same cycle: the write is processed as above and `re_i` is ignored.
  - If the write is dropped for busy, `re_i` still applies.
- Storage check every cycle: `err_storage_q` sets when `q_o` != ~`shadow_q`.
  - It stays set until reset.
  - It does not block further commits.
- `core_idle_i` falling while in STAGE1: the staged value is kept, and the confirming write is accepted once idle again.

## Timing
- All outputs are registered.
- Reset values:
  - `q_o`=RESVAL, `shadow_q`=~RESVAL
  - `staged_q`=0, `phase_o`=0
  - `qe_o`=0, `wr_ignored_o`=0, `err_update_o`=0, `err_storage_o`=0
- First write sampled at edge N: `phase_o`=1 from N+1.
- Confirming write sampled at edge M:
  - `q_o` carries the new value from M+1.
  - `qe_o` is high for exactly the cycle M+1.
  - `phase_o`=0 from M+1.
- `err_update_o` and `wr_ignored_o` are high for exactly one cycle, following the sampling edge.
- Back-to-back writes on consecutive cycles are legal; each edge is a separate phase step.
- Corruption present at edge K: `err_storage_o`=1 from K+1.
- Reset asserted mid-sequence: all state returns to the reset values asynchronously and the staged value is lost.
  - The first write after deassertion is treated as phase 0.

## Test plan
- Reset with RESVAL=32'h0000_0001:
  - `q_o`=32'h1, `phase_o`=0, all flags 0.
  - Internal `shadow_q`=32'hFFFF_FFFE.
- Idle core, write 32'h0000_0005 twice:
  - `phase_o` 0→1→0.
  - `q_o`=32'h5 one cycle after the second write, `qe_o` high for 1 cycle.
- Idle core, write 32'h5 then 32'h6:
  - `err_update_o` pulses once, `q_o` unchanged, `phase_o`=0.
  - Then write 32'h6 twice: `q_o`=32'h6.
- `core_idle_i`=0, write 32'hA:
  - `wr_ignored_o` pulses, `phase_o` stays 0, `q_o` unchanged.
  - Write 32'hA, drop idle, write 32'hA (ignored), raise idle, write 32'hA: commit to 32'hA.
- Write 32'h3, then `re_i`: `phase_o`=0.
  - Write 32'h3 once more: `phase_o`=1, no commit.
  - `re_i` and `we_i` (32'h3) together in STAGE1: commit occurs.
- Force `shadow_q` bit 0 flipped for one cycle:
  - `err_storage_o`=1 next cycle and stays 1 after the release.
  - Cleared only by asserting `rst_ni`=0 mid-sequence, which also returns `phase_o` to 0.

Source files
------------

// File: rtl/aes_ctrl_shadow_seq_if.sv
// Register-bus side of the AES shadowed control register: write/read strobes,
// core idle qualifier, committed word and status flags.
interface aes_ctrl_shadow_seq_if #(
  parameter int DW = 32
) ();
  logic          we_i;
  logic [DW-1:0] wdata_i;
  logic          re_i;
  logic          core_idle_i;
  logic [DW-1:0] q_o;
  logic          qe_o;
  logic          phase_o;
  logic          wr_ignored_o;
  logic          err_update_o;
  logic          err_storage_o;

  modport master (
    output we_i, wdata_i, re_i, core_idle_i,
    input  q_o, qe_o, phase_o, wr_ignored_o, err_update_o, err_storage_o
  );

  modport slave (
    input  we_i, wdata_i, re_i, core_idle_i,
    output q_o, qe_o, phase_o, wr_ignored_o, err_update_o, err_storage_o
  );
endinterface

// File: rtl/aes_ctrl_shadow_seq.sv
// Two-phase write sequencer for the AES shadowed control register: a value
// commits only when written twice in a row while the core is idle.
module aes_ctrl_shadow_seq #(
  parameter int          DW     = 32,
  parameter logic [DW-1:0] RESVAL = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  aes_ctrl_shadow_seq_if.slave        bus
);

  typedef enum logic {
    STAGE0 = 1'b0,
    STAGE1 = 1'b1
  } phase_t;

  phase_t        phase_q;
  logic [DW-1:0] staged_q;
  logic [DW-1:0] q_q;
  logic [DW-1:0] shadow_q;
  logic          qe_q;
  logic          wr_ignored_q;
  logic          err_update_q;
  logic          err_storage_q;
  logic          wr_accept_s;

  // The redundant copy is kept inverted so a stuck bus or cell cannot make both agree.
  function automatic logic copies_disagree(input logic [DW-1:0] q,
                                           input logic [DW-1:0] shadow);
    return (q != ~shadow);
  endfunction

  assign wr_accept_s = bus.we_i & bus.core_idle_i;

  // Phase sequencer, committed/redundant storage and registered status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q       <= STAGE0;
      staged_q      <= {DW{1'b0}};
      q_q           <= RESVAL;
      shadow_q      <= ~RESVAL;
      qe_q          <= 1'b0;
      wr_ignored_q  <= 1'b0;
      err_update_q  <= 1'b0;
      err_storage_q <= 1'b0;
    end else begin
      qe_q          <= 1'b0;
      wr_ignored_q  <= 1'b0;
      err_update_q  <= 1'b0;
      err_storage_q <= err_storage_q | copies_disagree(q_q, shadow_q);
      if (wr_accept_s) begin
        case (phase_q)
          STAGE0: begin
            staged_q <= bus.wdata_i;
            phase_q  <= STAGE1;
          end
          STAGE1: begin
            if (bus.wdata_i == staged_q) begin
              q_q      <= bus.wdata_i;
              shadow_q <= ~bus.wdata_i;
              qe_q     <= 1'b1;
            end else begin
              err_update_q <= 1'b1;
            end
            phase_q <= STAGE0;
          end
          default: begin
            phase_q <= STAGE0;
          end
        endcase
      end else begin
        wr_ignored_q <= bus.we_i;
        // A read of the register abandons a half-finished update.
        if (bus.re_i && (phase_q == STAGE1)) begin
          phase_q  <= STAGE0;
          staged_q <= {DW{1'b0}};
        end else begin
          phase_q  <= phase_q;
        end
      end
    end
  end

  assign bus.q_o           = q_q;
  assign bus.qe_o          = qe_q;
  assign bus.phase_o       = phase_q;
  assign bus.wr_ignored_o  = wr_ignored_q;
  assign bus.err_update_o  = err_update_q;
  assign bus.err_storage_o = err_storage_q;

endmodule

// File: tb/tb_aes_ctrl_shadow_seq.sv
// Directed bench for aes_ctrl_shadow_seq: double-write commit, mismatch,
// busy drops, read abort, storage corruption and mid-sequence reset.
module tb_aes_ctrl_shadow_seq;
  logic clk_i;
  logic rst_ni;
  int   n_checks;
  int   n_errors;

  aes_ctrl_shadow_seq_if #(.DW(32)) bus ();

  aes_ctrl_shadow_seq #(
    .DW     (32),
    .RESVAL (32'h0000_0001)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of bus inputs, then land 1ns after the sampling edge.
  task automatic step(input logic we, input logic [31:0] wd, input logic re, input logic idle);
    bus.we_i        = we;
    bus.wdata_i     = wd;
    bus.re_i        = re;
    bus.core_idle_i = idle;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_ni          = 1'b0;
    bus.we_i        = 1'b0;
    bus.wdata_i     = 32'h0;
    bus.re_i        = 1'b0;
    bus.core_idle_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check("rst_q", {31'h0, 1'b0} | bus.q_o, 32'h1);
    check("rst_shadow", dut.shadow_q, 32'hFFFF_FFFE);
    check("rst_phase", {31'h0, bus.phase_o}, 32'h0);
    check("rst_flags", {28'h0, bus.qe_o, bus.wr_ignored_o, bus.err_update_o, bus.err_storage_o}, 32'h0);
    rst_ni = 1'b1;

    // Matching double write commits.
    step(1'b1, 32'h5, 1'b0, 1'b1);
    check("w1_phase", {31'h0, bus.phase_o}, 32'h1);
    check("w1_qe", {31'h0, bus.qe_o}, 32'h0);
    step(1'b1, 32'h5, 1'b0, 1'b1);
    check("w2_q", bus.q_o, 32'h5);
    check("w2_qe", {31'h0, bus.qe_o}, 32'h1);
    check("w2_phase", {31'h0, bus.phase_o}, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("qe_one_cycle", {31'h0, bus.qe_o}, 32'h0);

    // Mismatching second write.
    step(1'b1, 32'h5, 1'b0, 1'b1);
    step(1'b1, 32'h6, 1'b0, 1'b1);
    check("mm_err", {31'h0, bus.err_update_o}, 32'h1);
    check("mm_q", bus.q_o, 32'h5);
    check("mm_phase", {31'h0, bus.phase_o}, 32'h0);
    step(1'b1, 32'h6, 1'b0, 1'b1);
    check("mm_err_pulse", {31'h0, bus.err_update_o}, 32'h0);
    step(1'b1, 32'h6, 1'b0, 1'b1);
    check("mm_recommit", bus.q_o, 32'h6);

    // Busy core drops writes; staged value survives the busy window.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    check("busy_ign", {31'h0, bus.wr_ignored_o}, 32'h1);
    check("busy_phase", {31'h0, bus.phase_o}, 32'h0);
    check("busy_q", bus.q_o, 32'h6);
    step(1'b1, 32'hA, 1'b0, 1'b1);
    step(1'b1, 32'hA, 1'b0, 1'b0);
    check("busy_s1_ign", {31'h0, bus.wr_ignored_o}, 32'h1);
    check("busy_s1_phase", {31'h0, bus.phase_o}, 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("busy_ign_pulse", {31'h0, bus.wr_ignored_o}, 32'h0);
    step(1'b1, 32'hA, 1'b0, 1'b1);
    check("busy_commit", bus.q_o, 32'hA);
    check("busy_commit_qe", {31'h0, bus.qe_o}, 32'h1);

    // Read abandons a staged value; read alongside an accepted write is ignored.
    step(1'b1, 32'h3, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("rd_phase", {31'h0, bus.phase_o}, 32'h0);
    check("rd_staged", dut.staged_q, 32'h0);
    step(1'b1, 32'h3, 1'b0, 1'b1);
    check("rd_restage", {31'h0, bus.phase_o}, 32'h1);
    check("rd_nocommit", bus.q_o, 32'hA);
    step(1'b1, 32'h3, 1'b1, 1'b1);
    check("rdwr_commit", bus.q_o, 32'h3);
    check("rdwr_phase", {31'h0, bus.phase_o}, 32'h0);
    step(1'b1, 32'h7, 1'b0, 1'b1);
    step(1'b1, 32'h7, 1'b1, 1'b0);
    check("rd_busy_ign", {31'h0, bus.wr_ignored_o}, 32'h1);
    check("rd_busy_phase", {31'h0, bus.phase_o}, 32'h0);
    check("rd_busy_q", bus.q_o, 32'h3);

    // Corrupt redundant copy for one cycle.
    bus.we_i = 1'b0;
    bus.re_i = 1'b0;
    check("sto_clean", {31'h0, bus.err_storage_o}, 32'h0);
    force dut.shadow_q = 32'hFFFF_FFFD;
    @(posedge clk_i);
    #1;
    release dut.shadow_q;
    check("sto_set", {31'h0, bus.err_storage_o}, 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("sto_sticky", {31'h0, bus.err_storage_o}, 32'h1);
    step(1'b1, 32'h9, 1'b0, 1'b1);
    step(1'b1, 32'h9, 1'b0, 1'b1);
    check("sto_commit", bus.q_o, 32'h9);
    check("sto_still", {31'h0, bus.err_storage_o}, 32'h1);

    // Asynchronous reset mid-sequence.
    step(1'b1, 32'h4, 1'b0, 1'b1);
    check("pre_rst_phase", {31'h0, bus.phase_o}, 32'h1);
    bus.we_i = 1'b0;
    rst_ni   = 1'b0;
    #1;
    check("arst_phase", {31'h0, bus.phase_o}, 32'h0);
    check("arst_sto", {31'h0, bus.err_storage_o}, 32'h0);
    check("arst_q", bus.q_o, 32'h1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step(1'b1, 32'h4, 1'b0, 1'b1);
    check("post_rst_w1", {31'h0, bus.phase_o}, 32'h1);
    check("post_rst_noqe", {31'h0, bus.qe_o}, 32'h0);
    step(1'b1, 32'h4, 1'b0, 1'b1);
    check("post_rst_commit", bus.q_o, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
